// File: rtl/eth_arp_payload_tx.sv
// rtl/eth_arp_payload_tx.sv - ARP payload byte serialiser (optional padding via ARP_PAD_EN)
module eth_arp_payload_tx #(
  parameter logic [15:0] HTYPE    = 16'h0001,
  parameter logic [15:0] PTYPE    = 16'h0800,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        eth_header_arp_tx_done,
  input  logic [15:0] arp_oper,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  input  logic [47:0] tha,
  input  logic [31:0] tpa,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        arp_payload_tx_done
);

`ifdef ARP_PAD_EN
  typedef enum logic [2:0] {
    WAIT_START, FIXED_TX, SHA_TX, SPA_TX, THA_TX, TPA_TX, PAD_TX
  } state_t;
`else
  typedef enum logic [2:0] {
    WAIT_START, FIXED_TX, SHA_TX, SPA_TX, THA_TX, TPA_TX
  } state_t;
`endif

  state_t      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [7:0]  data_d;
  logic        valid_d, busy_d, done_d, load;
  logic [15:0] oper_q;
  logic [47:0] sha_q, tha_q;
  logic [31:0] spa_q, tpa_q;
  logic [63:0] fixed_word;
  logic [2:0]  rev8, rev6;
  logic [1:0]  rev4;
  logic [7:0]  cur_byte;

  // Byte index counted from the MSB end of each field
  assign fixed_word = {HTYPE, PTYPE, 8'h06, 8'h04, oper_q};
  assign rev8 = 3'd7 - cnt[2:0];
  assign rev6 = 3'd5 - cnt[2:0];
  assign rev4 = 2'd3 - cnt[1:0];

  always_comb begin
    cur_byte = PAD_BYTE;
    case (state)
      WAIT_START: cur_byte = HTYPE[15:8];
      FIXED_TX:   cur_byte = fixed_word[{rev8, 3'b000} +: 8];
      SHA_TX:     cur_byte = sha_q[{rev6, 3'b000} +: 8];
      SPA_TX:     cur_byte = spa_q[{rev4, 3'b000} +: 8];
      THA_TX:     cur_byte = tha_q[{rev6, 3'b000} +: 8];
      TPA_TX:     cur_byte = tpa_q[{rev4, 3'b000} +: 8];
      default:    cur_byte = PAD_BYTE;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = data_out;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    if (state != WAIT_START) begin
      data_d  = cur_byte;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      cnt_d   = cnt + 5'd1;
    end
    case (state)
      WAIT_START: begin
        if (eth_header_arp_tx_done) begin
          load    = 1'b1;
          data_d  = cur_byte;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 5'd1;
          state_d = FIXED_TX;
        end
      end
      FIXED_TX: if (cnt == 5'd7) begin state_d = SHA_TX; cnt_d = 5'd0; end
      SHA_TX:   if (cnt == 5'd5) begin state_d = SPA_TX; cnt_d = 5'd0; end
      SPA_TX:   if (cnt == 5'd3) begin state_d = THA_TX; cnt_d = 5'd0; end
      THA_TX:   if (cnt == 5'd5) begin state_d = TPA_TX; cnt_d = 5'd0; end
      TPA_TX: begin
        if (cnt == 5'd3) begin
          cnt_d = 5'd0;
`ifdef ARP_PAD_EN
          state_d = PAD_TX;
`else
          state_d = WAIT_START;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef ARP_PAD_EN
      PAD_TX: begin
        if (cnt == 5'd17) begin
          cnt_d   = 5'd0;
          state_d = WAIT_START;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = WAIT_START;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state               <= WAIT_START;
      cnt                 <= 5'd0;
      data_out            <= 8'h00;
      data_valid          <= 1'b0;
      busy                <= 1'b0;
      arp_payload_tx_done <= 1'b0;
    end else begin
      state               <= state_d;
      cnt                 <= cnt_d;
      data_out            <= data_d;
      data_valid          <= valid_d;
      busy                <= busy_d;
      arp_payload_tx_done <= done_d;
    end
  end

  // Field snapshot for the frame in flight; only refreshed on an accepted start
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      oper_q <= 16'h0;
      sha_q  <= 48'h0;
      spa_q  <= 32'h0;
      tha_q  <= 48'h0;
      tpa_q  <= 32'h0;
    end else if (load) begin
      oper_q <= arp_oper;
      sha_q  <= sha;
      spa_q  <= spa;
      tha_q  <= tha;
      tpa_q  <= tpa;
    end
  end

endmodule

// File: tb/tb_eth_arp_payload_tx.sv
// tb/tb_eth_arp_payload_tx.sv - directed self-checking bench for eth_arp_payload_tx
module tb_eth_arp_payload_tx;

`ifdef ARP_PAD_EN
  localparam int LEN = 46;
`else
  localparam int LEN = 28;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] arp_oper = 16'h0;
  logic [47:0] sha = 48'h0;
  logic [31:0] spa = 32'h0;
  logic [47:0] tha = 48'h0;
  logic [31:0] tpa = 32'h0;
  logic [7:0]  data_out;
  logic        data_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_reply [0:27] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h01,
    8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hC0, 8'hA8, 8'h00, 8'h02};
  logic [7:0] exp_req [0:27] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h0A, 8'h00, 8'h00, 8'h01,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'hFE};
  logic [7:0] exp_cur [0:27];

  eth_arp_payload_tx dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .eth_header_arp_tx_done (start),
    .arp_oper               (arp_oper),
    .sha                    (sha),
    .spa                    (spa),
    .tha                    (tha),
    .tpa                    (tpa),
    .data_out               (data_out),
    .data_valid             (data_valid),
    .busy                   (busy),
    .arp_payload_tx_done    (done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_reply();
    arp_oper = 16'd2;
    sha = 48'h02_00_00_00_00_01;
    spa = 32'hC0A8_0001;
    tha = 48'hAA_BB_CC_DD_EE_FF;
    tpa = 32'hC0A8_0002;
  endtask

  // Pulse start; returns #1 after the accepting edge with byte 0 on the outputs
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // hook: 0 none, 1 corrupt inputs at hook_byte, 2 extra start at hook_byte, 3 restart in done cycle
  task automatic play_frame(input string tag, input int hook, input int hook_byte);
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("%s byte%0d data", tag, i), {8'h0, data_out}, {8'h0, (i < 28) ? exp_cur[i] : 8'h00});
      chk($sformatf("%s byte%0d valid", tag, i), {15'h0, data_valid}, 16'd1);
      chk($sformatf("%s byte%0d done", tag, i), {15'h0, done}, {15'h0, (i == LEN - 1)});
      chk($sformatf("%s byte%0d busy", tag, i), {15'h0, busy}, {15'h0, (i != LEN - 1)});
      if (hook == 1 && i == hook_byte) begin
        sha = '1;
        tpa = '1;
      end
      if (hook == 2 && i == hook_byte) start = 1'b1;
      if (hook == 3 && i == LEN - 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    if (hook != 3) begin
      chk({tag, " post valid"}, {15'h0, data_valid}, 16'd0);
      chk({tag, " post done"}, {15'h0, done}, 16'd0);
      chk({tag, " post busy"}, {15'h0, busy}, 16'd0);
    end
  endtask

  initial begin
    step();
    step();
    chk("reset data", {8'h0, data_out}, 16'h0000);
    chk("reset valid", {15'h0, data_valid}, 16'd0);
    chk("reset busy", {15'h0, busy}, 16'd0);
    chk("reset done", {15'h0, done}, 16'd0);
    aresetn = 1'b1;
    step();
    chk("idle valid", {15'h0, data_valid}, 16'd0);

    // Reply frame from the test plan
    set_reply();
    exp_cur = exp_reply;
    kick();
    play_frame("reply", 0, 0);
    step();

    // Request frame with a different field pattern
    arp_oper = 16'd1;
    sha = 48'h11_22_33_44_55_66;
    spa = 32'h0A00_0001;
    tha = 48'h0;
    tpa = 32'h0A00_00FE;
    exp_cur = exp_req;
    kick();
    play_frame("request", 0, 0);

    // Inputs changed mid-frame must not leak into the frame
    set_reply();
    exp_cur = exp_reply;
    kick();
    play_frame("latch", 1, 5);
    set_reply();

    // Extra start mid-frame is ignored
    kick();
    play_frame("extra_start", 2, 10);

    // Back-to-back frames: start in the done cycle
    kick();
    play_frame("b2b_first", 3, 0);
    play_frame("b2b_second", 0, 0);

    // Reset at byte 15 aborts the frame
    kick();
    for (int i = 0; i < 15; i++) step();
    chk("pre_reset data", {8'h0, data_out}, {8'h0, exp_reply[15]});
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    chk("mid_reset data", {8'h0, data_out}, 16'h0000);
    chk("mid_reset valid", {15'h0, data_valid}, 16'd0);
    chk("mid_reset busy", {15'h0, busy}, 16'd0);
    chk("mid_reset done", {15'h0, done}, 16'd0);
    step();
    chk("after_reset valid", {15'h0, data_valid}, 16'd0);
    chk("after_reset done", {15'h0, done}, 16'd0);
    kick();
    play_frame("after_reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
